// File: rtl/dwt_ctrl_pkg.sv
// Shared types and constants for the 9/7 DWT sequencer.
// Phase numbering doubles as the lifting-step index driven onto the datapath selects.
package dwt_ctrl_pkg;

    localparam int MAX_LEVELS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOT = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] phase_t;

    localparam phase_t ALPHA = 2'd0;
    localparam phase_t BETA  = 2'd1;
    localparam phase_t GAMMA = 2'd2;
    localparam phase_t DELTA = 2'd3;

    // Delay-unit enable index: four phases per level bank, level bank a..d.
    function automatic logic [3:0] en_d_index(input logic [1:0] level_m1, input phase_t phase);
        return {level_m1, phase};
    endfunction

endpackage

// File: rtl/dwt_slot_sched.sv
// Combinational slot picker: the deepest level holding a full pair wins, else level 1.
// Output level is encoded as level minus 1.
module dwt_slot_sched
    import dwt_ctrl_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic [MAX_LEVELS-1:1][1:0]      pend,
    input  logic [MAX_LEVELS-1:0][LEN_W-1:0] rem,
    input  logic [2:0]                      levels,
    output logic [1:0]                      level,
    output logic                            valid
);

    always_comb begin
        level = 2'd0;
        valid = 1'b0;
        if (rem[0] != '0) begin
            level = 2'd0;
            valid = 1'b1;
        end
        // Later iterations override earlier ones, so the highest ready level wins.
        for (int k = 1; k < MAX_LEVELS; k++) begin
            if (pend[k] == 2'd2 && rem[k] != '0 && 3'(k) < levels) begin
                level = 2'(k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dwt97_ctrl.sv
// Sequencer for the time-multiplexed recursive 9/7 lifting datapath.
// One slot = four phases on the shared MAC; slots of all levels are interleaved.
module dwt97_ctrl #(
    parameter int LEN_W      = 16,
    parameter int MAX_LEVELS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [2:0]       levels,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [11:0]      sel,
    output logic             s7,
    output logic [3:0]       en_r,
    output logic [15:0]      en_d,
    output logic             out_valid,
    output logic [1:0]       out_level,
    output logic             busy,
    output logic             done,
    output logic             err
);

    import dwt_ctrl_pkg::*;

    state_t                          state_reg, state_next;
    phase_t                          phase_reg, phase_next;
    logic [1:0]                      level_reg, level_next;
    logic [2:0]                      levels_reg, levels_next;
    logic [MAX_LEVELS-1:1][1:0]      pend_reg, pend_next, pend_inc;
    logic [MAX_LEVELS-1:0][LEN_W-1:0] rem_reg, rem_next;
    logic                            err_reg, err_next;

    logic [1:0]       sched_level;
    logic             sched_valid;
    logic [LEN_W-1:0] len_mask;
    logic             cfg_ok;
    logic             take_phase;
    logic             stall;
    logic             slot_end;

    assign len_mask = (LEN_W'(1) << levels) - LEN_W'(1);
    assign cfg_ok   = (levels != 3'd0) && (levels <= 3'(MAX_LEVELS)) &&
                      (len != '0) && ((len & len_mask) == '0);

    // Level-1 phases alpha/beta consume the even/odd input sample.
    assign take_phase = (state_reg == SLOT) && (level_reg == 2'd0) &&
                        (phase_reg == ALPHA || phase_reg == BETA);
    assign stall      = take_phase && !in_valid;
    assign slot_end   = (state_reg == SLOT) && (phase_reg == DELTA);

    // A finished level-k slot hands one L sample to level k+1 (if that level is in use).
    for (genvar gi = 1; gi < MAX_LEVELS; gi++) begin : g_pend_inc
        assign pend_inc[gi] = (slot_end && level_reg == 2'(gi - 1) && 3'(gi) < levels_reg) ?
                              pend_reg[gi] + 2'd1 : pend_reg[gi];
    end

    dwt_slot_sched #(
        .LEN_W (LEN_W)
    ) u_sched (
        .pend   (pend_inc),
        .rem    (rem_reg),
        .levels (levels_reg),
        .level  (sched_level),
        .valid  (sched_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            phase_reg  <= ALPHA;
            level_reg  <= 2'd0;
            levels_reg <= 3'd0;
            pend_reg   <= '0;
            rem_reg    <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            phase_reg  <= phase_next;
            level_reg  <= level_next;
            levels_reg <= levels_next;
            pend_reg   <= pend_next;
            rem_reg    <= rem_next;
            err_reg    <= err_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        phase_next  = phase_reg;
        level_next  = level_reg;
        levels_next = levels_reg;
        pend_next   = pend_reg;
        rem_next    = rem_reg;
        err_next    = 1'b0;

        in_ready  = 1'b0;
        sel       = '0;
        s7        = 1'b0;
        en_r      = '0;
        en_d      = '0;
        out_valid = 1'b0;
        out_level = 2'd0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = err_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        state_next  = SLOT;
                        phase_next  = ALPHA;
                        level_next  = 2'd0;
                        levels_next = levels;
                        pend_next   = '0;
                        for (int k = 0; k < MAX_LEVELS; k++) begin
                            rem_next[k] = (3'(k) < levels) ? (len >> (k + 1)) : '0;
                        end
                        // The first slot is always level 1 and starts right away.
                        rem_next[0] = (len >> 1) - LEN_W'(1);
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end

            SLOT: begin
                in_ready  = take_phase;
                sel       = {6{phase_reg}};
                s7        = (level_reg != 2'd0);
                out_valid = (phase_reg == DELTA);
                out_level = level_reg;
                busy      = 1'b1;
                if (!stall) begin
                    en_r[phase_reg]                        = 1'b1;
                    en_d[en_d_index(level_reg, phase_reg)] = 1'b1;
                    if (phase_reg != DELTA) begin
                        phase_next = phase_reg + 2'd1;
                    end else begin
                        pend_next = pend_inc;
                        if (sched_valid) begin
                            phase_next = ALPHA;
                            level_next = sched_level;
                            for (int k = 0; k < MAX_LEVELS; k++) begin
                                if (sched_level == 2'(k)) begin
                                    rem_next[k] = rem_reg[k] - LEN_W'(1);
                                end
                            end
                            for (int k = 1; k < MAX_LEVELS; k++) begin
                                if (sched_level == 2'(k)) begin
                                    pend_next[k] = pend_inc[k] - 2'd2;
                                end
                            end
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
            end

            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dwt97_ctrl.sv
// Directed-vector bench for dwt97_ctrl: each cycle compares the full output vector
// against a hand-derived slot schedule.
module tb_dwt97_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] len;
    logic [2:0]  levels;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] sel;
    logic        s7;
    logic [3:0]  en_r;
    logic [15:0] en_d;
    logic        out_valid;
    logic [1:0]  out_level;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    localparam logic [39:0] DONE_V = 40'h6;
    localparam logic [39:0] ERR_V  = 40'h1;

    logic [39:0] obs;
    assign obs = {sel, s7, en_r, en_d, in_ready, out_valid,
                  (out_valid ? out_level : 2'b00), busy, done, err};

    dwt97_ctrl #(
        .LEN_W      (16),
        .MAX_LEVELS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .levels    (levels),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .s7        (s7),
        .en_r      (en_r),
        .en_d      (en_d),
        .out_valid (out_valid),
        .out_level (out_level),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected output vector for level k, phase p (stl = input stall this cycle).
    function automatic logic [39:0] exp_slot(input int k, input int p, input bit stl);
        logic [11:0] s;
        logic [3:0]  r;
        logic [15:0] d;
        logic [1:0]  pp;
        pp = 2'(p);
        s  = {6{pp}};
        r  = stl ? 4'd0 : 4'(1 << p);
        d  = stl ? 16'd0 : 16'(1 << ((k - 1) * 4 + p));
        return {s, 1'(k >= 2), r, d, 1'(k == 1 && p < 2), 1'(p == 3),
                (p == 3) ? 2'(k - 1) : 2'b00, 1'b1, 1'b0, 1'b0};
    endfunction

    // Pulse start so it is sampled at edge 0; returns #1 into cycle 1.
    task automatic do_start(input logic [15:0] l, input logic [2:0] lv);
        start  = 1'b1;
        len    = l;
        levels = lv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (obs !== 40'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, 40'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 40'h0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected %h", obs, 40'h0);
        end
        $display("test_reset complete");
    endtask

    task automatic test_nominal();
        int lv[6] = '{1, 1, 2, 1, 1, 2};
        logic [39:0] expv;
        do_start(16'd8, 3'd2);
        for (int c = 1; c <= 26; c++) begin
            if (c <= 24)      expv = exp_slot(lv[(c - 1) / 4], (c - 1) % 4, 1'b0);
            else if (c == 25) expv = DONE_V;
            else              expv = 40'h0;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL nominal cycle %0d: got %h expected %h", c, obs, expv);
            end
            @(posedge clk);
            #1;
        end
        $display("test_nominal complete: len=8 levels=2");
    endtask

    task automatic test_stall();
        int lv[6] = '{1, 1, 2, 1, 1, 2};
        int e;
        logic [39:0] expv;
        do_start(16'd8, 3'd2);
        for (int c = 1; c <= 29; c++) begin
            in_valid = !(c >= 6 && c <= 8);
            #1;
            if (c >= 6 && c <= 8) begin
                expv = exp_slot(1, 1, 1'b1);
            end else begin
                e = (c > 8) ? c - 3 : c;
                if (e <= 24)      expv = exp_slot(lv[(e - 1) / 4], (e - 1) % 4, 1'b0);
                else if (e == 25) expv = DONE_V;
                else              expv = 40'h0;
            end
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL stall cycle %0d: got %h expected %h", c, obs, expv);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        $display("test_stall complete: 3 stall cycles");
    endtask

    task automatic test_illegal();
        logic [15:0] l_tab[4] = '{16'd12, 16'd8, 16'd8, 16'd0};
        logic [2:0]  v_tab[4] = '{3'd3,   3'd0,  3'd5,  3'd1};
        for (int i = 0; i < 4; i++) begin
            do_start(l_tab[i], v_tab[i]);
            checks++;
            if (obs !== ERR_V) begin
                errors++;
                $display("FAIL illegal_err len=%0d levels=%0d: got %h expected %h",
                         l_tab[i], v_tab[i], obs, ERR_V);
            end
            @(posedge clk);
            #1;
            checks++;
            if (obs !== 40'h0) begin
                errors++;
                $display("FAIL illegal_idle len=%0d levels=%0d: got %h expected %h",
                         l_tab[i], v_tab[i], obs, 40'h0);
            end
            $display("test_illegal len=%0d levels=%0d complete", l_tab[i], v_tab[i]);
        end
    endtask

    task automatic test_full_depth();
        int lv[15] = '{1, 1, 2, 1, 1, 2, 3, 1, 1, 2, 1, 1, 2, 3, 4};
        logic [39:0] expv;
        do_start(16'd16, 3'd4);
        for (int c = 1; c <= 62; c++) begin
            if (c <= 60)      expv = exp_slot(lv[(c - 1) / 4], (c - 1) % 4, 1'b0);
            else if (c == 61) expv = DONE_V;
            else              expv = 40'h0;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL full_depth cycle %0d: got %h expected %h", c, obs, expv);
            end
            for (int k = 1; k < 4; k++) begin
                checks++;
                if (dut.pend_reg[k] > 2'd2) begin
                    errors++;
                    $display("FAIL pend_bound cycle %0d level %0d: got %0d expected <=2",
                             c, k + 1, dut.pend_reg[k]);
                end
            end
            @(posedge clk);
            #1;
        end
        $display("test_full_depth complete: len=16 levels=4");
    endtask

    task automatic test_reset_mid();
        logic [39:0] expv;
        do_start(16'd8, 3'd2);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        // Now in cycle 11: phase 2 of slot 3.
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 40'h0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h expected %h", obs, 40'h0);
        end
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== 40'h0) begin
            errors++;
            $display("FAIL reset_mid_idle: got %h expected %h", obs, 40'h0);
        end
        do_start(16'd8, 3'd1);
        for (int c = 1; c <= 18; c++) begin
            if (c <= 16)      expv = exp_slot(1, (c - 1) % 4, 1'b0);
            else if (c == 17) expv = DONE_V;
            else              expv = 40'h0;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL reset_mid_restart cycle %0d: got %h expected %h", c, obs, expv);
            end
            @(posedge clk);
            #1;
        end
        $display("test_reset_mid complete");
    endtask

    task automatic test_start_busy();
        int lv[6] = '{1, 1, 2, 1, 1, 2};
        logic [39:0] expv;
        do_start(16'd8, 3'd2);
        for (int c = 1; c <= 26; c++) begin
            start = (c == 3 || c == 13);
            if (start) begin
                len    = 16'd16;
                levels = 3'd1;
            end
            #1;
            if (c <= 24)      expv = exp_slot(lv[(c - 1) / 4], (c - 1) % 4, 1'b0);
            else if (c == 25) expv = DONE_V;
            else              expv = 40'h0;
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL start_busy cycle %0d: got %h expected %h", c, obs, expv);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        $display("test_start_busy complete");
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        len      = 16'd0;
        levels   = 3'd0;
        in_valid = 1'b1;
        #1;
        test_reset();
        test_nominal();
        test_stall();
        test_illegal();
        test_full_depth();
        test_reset_mid();
        test_start_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dwt97_ctrl.md
# dwt97_ctrl

Sequencer for the recursive one-dimensional 9/7 DWT datapath (`transform`). It drives every mux select (`S1`–`S7`), register enable (`EnR1`–`EnR4`) and delay-unit enable (`EnD1a`–`EnD4d`). Processing is time-multiplexed: each sample pair runs the four lifting steps (alpha, beta, gamma, delta) in four consecutive cycles on the single shared MAC, and pairs from all decomposition levels are interleaved. The block handles input flow control and tags each L/H output with its level.

## Interface
- `LEN_W`, 16: width of the signal-length input.
- `MAX_LEVELS`, 4: maximum decomposition depth. Fixed at 4 (delay banks a–d).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle request to begin a transform.
- `len` in LEN_W: number of level-1 input samples, sampled with `start`.
- `levels` in 3: decomposition depth, 1..4, sampled with `start`.
- `in_valid` in 1: datapath input `x` holds a valid sample.
- `in_ready` out 1: sample on `x` is consumed this cycle.
- `sel` out 12: {S1,S2,S3,S4,S5,S6}, 2 bits each, S1 in the MSBs.
- `s7` out 1: datapath input select. 0 = `x`, 1 = feedback of the previous level's L.
- `en_r` out 4: EnR4..EnR1, one-hot or zero.
- `en_d` out 16: bit `(level-1)*4 + phase` maps to EnD<phase+1><a|b|c|d>.
- `out_valid` out 1: datapath L/H are valid this cycle.
- `out_level` out 2: level of the current L/H, minus 1.
- `busy` out 1: a transform is in progress.
- `done` out 1: single-cycle completion pulse.
- `err` out 1: single-cycle pulse when `start` carries an illegal configuration.

## Operation
- **States:** IDLE, SLOT, DONE.
  - In IDLE, all outputs are 0.
  - **IDLE→SLOT** on `start` when the configuration is legal: `1 <= levels <= 4`, `len != 0`, and `len` a multiple of `2^levels`.
  - An illegal `start` pulses `err` and the block stays in IDLE.
  - `start` is ignored outside IDLE.
- **Slot:** 4 phases, p = 0..3, with a 2-bit phase counter.
  - During phase p: every field of `sel` equals p, `en_r` = 1<<p, and `en_d` bit (k-1)*4+p is set, where k is the slot's level.
  - `s7` = 1 when k >= 2.
- **Level-1 slots:**
  - Phase 0 asserts `in_ready` to take the even sample; phase 1 asserts it to take the odd sample.
  - If `in_valid` = 0 while `in_ready` = 1, the phase holds (stall): `en_r` and `en_d` are 0 and the selects keep their value.
  - Phases 2 and 3 never stall.
- **Pending counters:** `pend[k]` for k = 2..levels, 2 bits each, reset to 0.
  - The end of a level-k slot (phase 3 advancing) increments `pend[k+1]` when k < levels.
  - Starting a level-k slot (k >= 2) subtracts 2 from `pend[k]`.
- **Remaining-pair counters:** `rem[k]`, loaded with `len >> k` on start, decremented at the start of each level-k slot.
- **Scheduler:** runs at every phase-0 entry.
  - Pick the highest k >= 2 with `pend[k]` = 2.
  - Otherwise pick k = 1 if `rem[1]` != 0.
  - A valid choice always exists until all `rem` are 0.
- **Output:** `out_valid` = 1 in phase 3 of every slot, with `out_level` = k-1. It is not gated by stalls, because phase 3 never stalls.
- **Completion:** when phase 3 ends and every `rem[k]` is 0, go to DONE for one cycle. DONE pulses `done`, keeps `busy` = 1, and then returns to IDLE.
- **Reset (including mid-transform):** immediately returns to IDLE and clears all counters. All outputs go to 0.

## Timing
- `start` is accepted at edge 0. Phase 0 of the first slot is in cycle 1.
- Without stalls, a slot takes exactly 4 cycles and there are no gaps between slots.
- Total slots = Σ_{k=1..levels} `len >> k`. `done` is asserted in cycle 4·slots + 1.
- `busy` is high from cycle 1 through the DONE cycle inclusive.
- Each input stall cycle delays `done` by one cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from `in_valid` to any output except through the stall gating of `en_r` and `en_d`.
- Invariant: `pend[k]` <= 2 at all times. The bench asserts it.

## Structure
- **`dwt_ctrl_pkg`:**
  - State enum (IDLE, SLOT, DONE).
  - Phase type (2 bits).
  - `MAX_LEVELS`.
  - Phase-to-step constants (ALPHA = 0, BETA = 1, GAMMA = 2, DELTA = 3).
  - A function mapping (level, phase) to an `en_d` index.
- **Sub-module `dwt_slot_sched`:** combinational priority pick. Inputs are `pend`, `rem` and `levels`; outputs are the chosen level and a valid flag.

## Test plan
1. **Nominal, 2 levels:** `len` = 8, `levels` = 2, `in_valid` held 1.
   - Slot levels are 1,1,2,1,1,2.
   - `out_level` sequence is 0,0,1,0,0,1.
   - `done` is in cycle 25 and `busy` drops in cycle 26.
2. **Stalls:** same setup, but `in_valid` = 0 for 3 cycles during phase 1 of the second slot.
   - `sel`, `en_r` and `en_d` are zero-enabled and held during the stall.
   - `done` is in cycle 28.
3. **Illegal configurations:**
   - `len` = 12, `levels` = 3 → `err` pulse, `busy` stays 0.
   - `levels` = 0 → `err`.
   - `levels` = 5 → `err`.
4. **Full depth:** `len` = 16, `levels` = 4.
   - 15 slots; `done` in cycle 61.
   - `en_d` bit 12+p is active in the last slot.
   - `pend` never exceeds 2.
5. **Reset mid-transform:** assert `rst` in phase 2 of slot 3.
   - All outputs are 0 asynchronously.
   - A subsequent `start` with `len` = 8, `levels` = 1 completes in 4 slots, `done` in cycle 17.
6. **Start while busy:** a `start` pulse mid-transform has no effect on the schedule or counters.
